hack_exec_ctrl: RTL

Execution controller for the Hack CPU. It sequences CPU reset, free-run, halt, single-step and PC breakpoints by driving a clock-enable and reset into the CPU. Run/step/reset requests arrive as one-cycle pulses from the debounced buttons, through an edge detector. The block sits between the I/O button logic and the CPU, in the single 100 MHz system domain.

---
 rtl/hack_pkg.sv | 13 +
 rtl/hack_exec_ctrl.sv | 116 +++++++++++
 2 files changed

// File: rtl/hack_pkg.sv
// Shared types and constants for the Hack CPU execution-control slice.
package hack_pkg;

   localparam int unsigned HACK_PC_W = 15;

   typedef enum logic [1:0] {
      ST_RST  = 2'd0,
      ST_HALT = 2'd1,
      ST_RUN  = 2'd2,
      ST_STEP = 2'd3
   } exec_state_t;

endpackage

// File: rtl/hack_exec_ctrl.sv
// Execution controller for the Hack CPU: sequences CPU reset, run, halt,
// single-step and PC breakpoints through a clock-enable and a CPU reset.
module hack_exec_ctrl
   import hack_pkg::*;
#(
   parameter int unsigned PC_W       = HACK_PC_W,
   parameter int unsigned CNT_W      = 32,
   parameter int unsigned RST_CYCLES = 4,
   parameter int unsigned AUTO_RUN   = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              run_req,
   input  logic              step_req,
   input  logic              soft_rst_req,
   input  logic              bp_en,
   input  logic [PC_W-1:0]   bp_addr,
   input  logic [PC_W-1:0]   pc,
   output logic              cpu_ce,
   output logic              cpu_reset,
   output exec_state_t       state,
   output logic              bp_hit,
   output logic [CNT_W-1:0]  instr_count
);

   localparam int unsigned    RC_W     = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
   localparam logic [RC_W-1:0] RC_LAST = RC_W'(RST_CYCLES - 1);
   localparam exec_state_t    POST_RST = (AUTO_RUN != 0) ? ST_RUN : ST_HALT;

   exec_state_t     state_q, state_d;
   logic [RC_W-1:0] rst_cnt_q, rst_cnt_d;
   logic            skip_q, skip_d;
   logic            bp_hit_d;
   logic            brk;

   // Skip masks the breakpoint so a resume from the break address executes it.
   assign brk   = bp_en && (pc == bp_addr) && !skip_q;
   assign state = state_q;

   // State register
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= ST_RST;
         rst_cnt_q <= '0;
         skip_q    <= 1'b0;
         bp_hit    <= 1'b0;
         cpu_reset <= 1'b1;
      end else begin
         state_q   <= state_d;
         rst_cnt_q <= rst_cnt_d;
         skip_q    <= skip_d;
         bp_hit    <= bp_hit_d;
         cpu_reset <= (state_d == ST_RST);
      end
   end

   // Next state and combinational clock enable
   always_comb begin
      state_d   = state_q;
      rst_cnt_d = '0;
      skip_d    = skip_q;
      bp_hit_d  = 1'b0;
      cpu_ce    = 1'b0;
      if (soft_rst_req) begin
         state_d = ST_RST;
         skip_d  = 1'b0;
      end else begin
         case (state_q)
            ST_RST: begin
               skip_d = 1'b0;
               if (rst_cnt_q == RC_LAST) begin
                  state_d = POST_RST;
               end else begin
                  rst_cnt_d = rst_cnt_q + RC_W'(1);
               end
            end
            ST_HALT: begin
               if (run_req) begin
                  state_d = ST_RUN;
                  skip_d  = 1'b1;
               end else if (step_req) begin
                  state_d = ST_STEP;
               end
            end
            ST_RUN: begin
               if (brk) begin
                  state_d  = ST_HALT;
                  bp_hit_d = 1'b1;
               end else if (run_req) begin
                  state_d = ST_HALT;
               end else begin
                  cpu_ce = 1'b1;
                  skip_d = 1'b0;
               end
            end
            ST_STEP: begin
               cpu_ce  = 1'b1;
               state_d = ST_HALT;
            end
            default: state_d = ST_RST;
         endcase
      end
   end

   // Saturating retired-instruction counter
   always_ff @(posedge clk) begin
      if (reset) begin
         instr_count <= '0;
      end else if (state_q == ST_RST) begin
         instr_count <= '0;
      end else if (cpu_ce && !cpu_reset && !(&instr_count)) begin
         instr_count <= instr_count + CNT_W'(1);
      end
   end

endmodule
